// File: rtl/add_serial_pkg.sv
// Shared definitions for the serial-adder operand sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package add_serial_pkg;

    localparam int WIDTH_DEFAULT   = 8;
    localparam int DEPTH_DEFAULT   = 4;
    // One load cycle followed by one shift per operand bit.
    localparam int LATENCY_DEFAULT = WIDTH_DEFAULT + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

endpackage

// File: rtl/add_serial_seq_fifo.sv
// Operand-pair FIFO: DW-bit wide, DEPTH entries, synchronous push/pop.
// Latency: a pushed entry is visible at o_head_dat the cycle after the push.
// Backpressure: pushes while full and pops while empty are ignored.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset (clears pointers/count)
//   i_push/i_push_dat write side
//   i_pop             drop the head entry
//   o_head_dat        current head entry (undefined when empty)
//   o_count           registered occupancy, 0..DEPTH
//   o_full/o_empty    derived from o_count
module add_serial_seq_fifo #(
    parameter int DW    = 16,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic [DW-1:0]              i_push_dat,
    input  logic                       i_pop,
    output logic [DW-1:0]              o_head_dat,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_full,
    output logic                       o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign o_full     = (r_count == (AW+1)'(DEPTH));
    assign o_empty    = (r_count == '0);
    assign o_count    = r_count;
    assign o_head_dat = r_mem[r_rd_ptr];

    assign w_push = i_push & ~o_full;
    assign w_pop  = i_pop & ~o_empty;

    // Storage carries no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_dat;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/add_serial_seq.sv
// Operand sequencer for the serial adder: queues pairs, issues one at a time, captures the sum.
// Latency: pair reaches the adder 2 cycles after acceptance; result valid LATENCY+1 cycles after add_en.
// Backpressure: in_ready drops when the FIFO is full; a result is held until res_ready.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset (adder shares rst)
//   in_valid/in_ready/in_a/b  operand pair input (valid/ready)
//   add_a/add_b/add_en        drive the adder; operands stay stable for the whole add
//   add_out                   adder result, final LATENCY cycles after the add_en cycle
//   res_valid/res_ready       result output (valid/ready)
//   res_sum                   captured sum, wraps mod 2^WIDTH
//   res_err                   adder self-check mismatch; only live when
//                             ADD_SERIAL_SEQ_CHECK_EN is defined, otherwise tied 0
module add_serial_seq
    import add_serial_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEFAULT,
    parameter int DEPTH   = DEPTH_DEFAULT,
    // Must be retuned together with WIDTH (WIDTH+1 for the serial adder).
    parameter int LATENCY = LATENCY_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_en,
    input  logic [WIDTH-1:0] add_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_sum,
    output logic             res_err
);
    localparam int CNT_W  = $clog2(LATENCY + 1);
    localparam int FCNT_W = $clog2(DEPTH) + 1;
    localparam int PAIR_W = 2 * WIDTH;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [WIDTH-1:0]  r_add_a;
    logic [WIDTH-1:0]  r_add_b;
    logic [WIDTH-1:0]  r_res_sum;
    logic              r_res_valid;

    logic [PAIR_W-1:0] w_head;
    logic [FCNT_W-1:0] w_fifo_count;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic              w_fifo_push;
    logic              w_load;
    logic              w_issue;
    logic              w_wait_done;
    logic              w_accept;

    // Registered count only: a pop in the same cycle does not open a slot early.
    assign in_ready    = (w_fifo_count != FCNT_W'(DEPTH));
    assign w_fifo_push = in_valid & ~w_fifo_full;

    // The head stays in the FIFO until its sum is captured, so a slot frees
    // only once the add has finished.
    add_serial_seq_fifo #(
        .DW    (PAIR_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_push     (w_fifo_push),
        .i_push_dat ({in_a, in_b}),
        .i_pop      (w_wait_done),
        .o_head_dat (w_head),
        .o_count    (w_fifo_count),
        .o_full     (w_fifo_full),
        .o_empty    (w_fifo_empty)
    );

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:  if (!w_fifo_empty)                              w_state_nxt = S_ISSUE;
            S_ISSUE:                                                 w_state_nxt = S_WAIT;
            S_WAIT:  if (r_cnt == CNT_W'(LATENCY))                   w_state_nxt = S_HOLD;
            S_HOLD:  if (r_res_valid && res_ready)                   w_state_nxt = S_IDLE;
            default:                                                 w_state_nxt = S_IDLE;
        endcase
    end

    // HOLD and IDLE each contribute one idle cycle between issues, which is
    // what lets the adder fall back to its own idle state.
    always_comb begin
        w_load      = 1'b0;
        w_issue     = 1'b0;
        w_wait_done = 1'b0;
        w_accept    = 1'b0;
        unique case (r_state)
            S_IDLE:  w_load      = ~w_fifo_empty;
            S_ISSUE: w_issue     = 1'b1;
            S_WAIT:  w_wait_done = (r_cnt == CNT_W'(LATENCY));
            S_HOLD:  w_accept    = r_res_valid & res_ready;
            default: ;
        endcase
    end

    // ----------------------------------------------------------- datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            r_add_a     <= '0;
            r_add_b     <= '0;
            r_cnt       <= '0;
            r_res_valid <= 1'b0;
            r_res_sum   <= '0;
        end else begin
            // Operands change only on IDLE->ISSUE and hold through WAIT/HOLD.
            if (w_load) begin
                {r_add_a, r_add_b} <= w_head;
            end

            // Counter value k in S_WAIT means k cycles have passed since add_en.
            if (w_issue) begin
                r_cnt <= CNT_W'(1);
            end else if (w_wait_done) begin
                r_cnt <= '0;
            end else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt + 1'b1;
            end

            if (w_wait_done) begin
                r_res_sum   <= add_out;
                r_res_valid <= 1'b1;
            end else if (w_accept) begin
                r_res_valid <= 1'b0;
            end
        end
    end

`ifdef ADD_SERIAL_SEQ_CHECK_EN
    logic [WIDTH-1:0] w_ref_sum;
    logic             r_res_err;

    // Truncating add: the expected value wraps exactly like the adder.
    assign w_ref_sum = r_add_a + r_add_b;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_res_err <= 1'b0;
        end else if (w_wait_done) begin
            r_res_err <= (add_out != w_ref_sum);
        end else if (w_accept) begin
            r_res_err <= 1'b0;
        end
    end

    assign res_err = r_res_err;
`else
    assign res_err = 1'b0;
`endif

    assign add_a     = r_add_a;
    assign add_b     = r_add_b;
    assign add_en    = w_issue;
    assign res_valid = r_res_valid;
    assign res_sum   = r_res_sum;

endmodule

// File: tb/tb_add_serial_seq.sv
// Bench for add_serial_seq: behavioural adder, input-side scoreboard feed, output monitor.
// Latency: checks result timing relative to add_en and FIFO occupancy against in_ready.
// Backpressure: res_ready driven held-low, held-high or random.
module tb_add_serial_seq;

    localparam int WIDTH   = 8;
    localparam int DEPTH   = 4;
    localparam int LATENCY = 9;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_a = '0;
    logic [WIDTH-1:0] in_b = '0;
    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic             add_en;
    logic [WIDTH-1:0] add_out;
    logic             res_valid;
    logic             res_ready = 1'b0;
    logic [WIDTH-1:0] res_sum;
    logic             res_err;

    always #5 clk = ~clk;

    add_serial_seq #(
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .LATENCY (LATENCY)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_en    (add_en),
        .add_out   (add_out),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_sum   (res_sum),
        .res_err   (res_err)
    );

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             err;
    } exp_t;

    exp_t exp_q[$];

    // Adder behaviour: a faulty answer is injected for the pair (0x08,0x09).
    function automatic logic [WIDTH-1:0] adder_model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] s;
        s = a + b;
        if (a == 8'h08 && b == 8'h09) s = 8'h10;
        return s;
    endfunction

    function automatic exp_t expect_of(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        exp_t             e;
        logic [WIDTH-1:0] true_sum;
        true_sum = a + b;
        e.sum    = adder_model(a, b);
`ifdef ADD_SERIAL_SEQ_CHECK_EN
        e.err    = (e.sum != true_sum);
`else
        e.err    = 1'b0;
`endif
        return e;
    endfunction

    // Serial adder stand-in: out shows a wrong value until LATENCY cycles after en.
    int               add_cnt = 0;
    logic [WIDTH-1:0] add_res = '0;
    always @(posedge clk) begin
        if (rst) begin
            add_cnt <= 0;
            add_res <= '0;
            add_out <= '0;
        end else if (add_en) begin
            add_res <= adder_model(add_a, add_b);
            add_out <= ~adder_model(add_a, add_b);
            add_cnt <= 1;
        end else if (add_cnt != 0) begin
            add_cnt <= add_cnt + 1;
            add_out <= (add_cnt + 1 >= LATENCY) ? add_res : ~add_res;
        end
    end

    // Input side: every accepted pair queues its expected result.
    always @(negedge clk) begin
        if (rst) exp_q.delete();
        else if (in_valid && in_ready) exp_q.push_back(expect_of(in_a, in_b));
    end

    // ------------------------------------------------------------ monitor
    int n_pass = 0;
    int n_checks = 0;
    int cyc = 0;
    int en_cyc = 0;
    int occ = 0;
    int tmo_req = 0;
    int tmo_seen = 0;
    bit done_req = 1'b0;
    bit done_seen = 1'b0;
    bit inflight = 1'b0;
    bit prev_rst = 1'b0;
    bit prev_push = 1'b0;
    bit prev_valid = 1'b0;
    bit prev_ready = 1'b0;
    bit prev_en = 1'b0;
    bit prev_err = 1'b0;
    logic [WIDTH-1:0] prev_sum = '0;
    logic [WIDTH-1:0] hold_a = '0;
    logic [WIDTH-1:0] hold_b = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (rst) begin
            occ       = 0;
            inflight  = 1'b0;
            prev_push = 1'b0;
            prev_en   = 1'b0;
        end else begin
            if (prev_rst) begin
                check("rst_in_ready",  in_ready,  1);
                check("rst_add_en",    add_en,    0);
                check("rst_add_a",     add_a,     0);
                check("rst_add_b",     add_b,     0);
                check("rst_res_valid", res_valid, 0);
                check("rst_res_sum",   res_sum,   0);
                check("rst_res_err",   res_err,   0);
            end

            // Occupancy: a pair leaves the FIFO on the edge its result appears.
            if (prev_push) occ++;
            if (res_valid && !prev_valid) occ--;
            check("in_ready", in_ready, (occ != DEPTH));

            if (add_en) begin
                check("en_single_pulse", prev_en, 0);
                en_cyc   = cyc;
                inflight = 1'b1;
                hold_a   = add_a;
                hold_b   = add_b;
            end else if (inflight) begin
                check("add_a_hold", add_a, hold_a);
                check("add_b_hold", add_b, hold_b);
            end

            if (res_valid && !prev_valid) check("res_latency", cyc - en_cyc, LATENCY + 1);

            if (prev_valid && !prev_ready) begin
                check("valid_held", res_valid, 1);
                check("sum_stable", res_sum, prev_sum);
                check("err_stable", res_err, prev_err);
            end
            if (prev_valid && prev_ready) begin
                check("valid_drop", res_valid, 0);
                check("err_cleared", res_err, 0);
            end

            if (res_valid && res_ready) begin
                check("result_expected", (exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("res_sum", res_sum, e.sum);
                    check("res_err", res_err, e.err);
                end
                inflight = 1'b0;
            end

            prev_push = in_valid && in_ready;
            prev_en   = add_en;
        end
        prev_rst   = rst;
        prev_valid = rst ? 1'b0 : res_valid;
        prev_ready = res_ready;
        prev_sum   = res_sum;
        prev_err   = res_err;

        if (tmo_req != tmo_seen) begin
            check("wait_budget", tmo_req - tmo_seen, 0);
            tmo_seen = tmo_req;
        end
        if (done_req && !done_seen) begin
            check("queue_drained", exp_q.size(), 0);
            done_seen = 1'b1;
        end
    end

    // ---------------------------------------------------------- stimulus
    int rr_mode = 0;   // 0: hold low, 1: hold high, 2: random
    initial forever begin
        @(posedge clk);
        #1;
        case (rr_mode)
            0:       res_ready = 1'b0;
            1:       res_ready = 1'b1;
            default: res_ready = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic push_pair(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        bit acc;
        int n;
        acc = 1'b0;
        n = 0;
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) tmo_req++;
        in_valid = 1'b0;
    endtask

    task automatic drain(input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(posedge clk);
            #1;
            ok = (exp_q.size() == 0) && !res_valid && !inflight;
        end
        if (!ok) tmo_req++;
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        bit seen;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Directed sums, including wrap and the injected adder fault.
        rr_mode = 1;
        push_pair(8'h35, 8'h4A);
        drain(100);
        push_pair(8'hFF, 8'h01);
        drain(100);
        push_pair(8'h08, 8'h09);
        drain(100);

        // Fill the FIFO while the output is blocked, then release.
        rr_mode = 0;
        for (int i = 0; i < 5; i++) push_pair(8'(8'h10 * i + 3), 8'(8'h21 + i));
        repeat (25) @(posedge clk);
        #1;
        rr_mode = 1;
        drain(500);

        // Reset while the first of two pairs is mid-add (counter at 4).
        push_pair(8'h11, 8'h22);
        push_pair(8'h33, 8'h44);
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            seen = add_en;
        end
        if (!seen) tmo_req++;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (30) @(posedge clk);
        #1;

        // Random pairs against a random downstream.
        rr_mode = 2;
        for (int i = 0; i < 200; i++) begin
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
            if (a == 8'h08 && b == 8'h09) b = 8'h0A;
            push_pair(a, b);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        drain(2000);

        done_req = 1'b1;
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
